aes_key_expand_ctrl: RTL and testbench
======================================

Name: aes_key_expand_ctrl

Overview:
Sequences the single-round subkey engine (gen_sub_key, 1 round per request) to expand an AES-128 cipher key into all 11 round keys. Stores the keys in an internal 11x128 register file and gives the cipher datapath a registered read port. Sits between the host key-load interface and the round pipeline. Owns the engine's opcode/Rcon/valid sequencing and guards against a hung engine with a watchdog.

Parameters:
KEY_LEN, 128, key and round-key width; only 128 is supported.
WORD_LEN, 32, word width used for Rcon.
NUM_ROUNDS, 10, number of expanded rounds; storage holds NUM_ROUNDS+1 keys.
ENG_TIMEOUT, 16, maximum cycles in WAIT before an error is flagged.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to expand key_in
key_in  in  KEY_LEN  cipher key, sampled in the start cycle
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when round key 10 has been written
keys_valid  out  1  high from done until the next accepted start or reset
error  out  1  sticky watchdog error; cleared by an accepted start or reset
rd_addr  in  4  round-key index 0..10
rd_data  out  KEY_LEN  round key at rd_addr, 1-cycle registered latency
eng_valid  out  1  request pulse to the engine
eng_data  out  KEY_LEN  previous round key presented to the engine
eng_opcode  out  1  always 0 (RotWord+SubWord+Rcon)
eng_rcon  out  WORD_LEN  {rc[r],24'h0}, held stable for the whole request
eng_valid_out  in  1  engine result strobe
eng_data_out  in  KEY_LEN  engine result

Behaviour:
- Reset (async, active-low): state IDLE; busy, done, keys_valid, error, eng_valid and rd_data are 0; eng_data and eng_rcon are 0; the round counter is 0. Key storage contents are not reset, but keys_valid=0 marks them invalid.
- FSM states: IDLE, ISSUE, WAIT, ERR.
- IDLE: if start=1, write key_mem[0]<=key_in, round<=1, eng_data<=key_in, and go to ISSUE. The same accept clears keys_valid and error. start is also accepted from ERR and from IDLE after a completed run.
- ISSUE (1 cycle): eng_valid=1, asserted combinationally from the state. eng_rcon = rc[round], with rc = 01,02,04,08,10,20,40,80,1B,36 in the MSB byte. Clear the watchdog counter and go to WAIT.
- WAIT: eng_valid=0. eng_data and eng_rcon stay unchanged, because the engine samples Rcon combinationally at its output stage.
  - On eng_valid_out: key_mem[round]<=eng_data_out and eng_data<=eng_data_out.
    - If round==NUM_ROUNDS: pulse done, set keys_valid, go to IDLE.
    - Otherwise: round++ and go to ISSUE.
  - Otherwise, increment the watchdog counter. When it reaches ENG_TIMEOUT, set error and go to ERR.
- ERR: busy=0, keys_valid=0. The block waits for start.
- busy=1 in ISSUE and WAIT.
- start while busy is ignored, with no restart and no effect on the current run.
- eng_valid_out outside WAIT is ignored and does not write storage.
- Timing with the nominal engine latency of 4 (eng_valid in cycle C, eng_valid_out in C+4):
  - start accepted in cycle 0, first ISSUE in cycle 1.
  - round r result arrives at cycle 5r.
  - done at cycle 51, counting the cycle after the round-10 write as the done cycle; done and keys_valid are registered.
  - 5 cycles per round.
- The controller must not depend on the exact engine latency; only the watchdog bounds it.
- Read port: rd_data<=key_mem[rd_addr] every cycle, whatever busy is. rd_addr>10 returns 0. A read of the same slot in the cycle it is written returns the old value.
- Reset mid-run aborts immediately: busy=0, and the engine is left to flush because its late strobes are ignored in IDLE.

Decomposition:
- Shared package aes_pkg: KEY_LEN/WORD_LEN constants, the Rcon table function rcon(r), NUM_ROUNDS_128, and the state enum encoding.
- One natural sub-module, aes_round_key_rf: the 11x128 register file with a synchronous write port and a registered read port.
- The FSM, round counter and watchdog stay in aes_key_expand_ctrl.

Test Plan:
- FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start, real engine attached -> done at cycle 51. rd_addr=1 gives a0fafe17_88542cb1_23a33939_2a6c7605; rd_addr=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- Rcon/opcode check: monitor each ISSUE -> eng_rcon sequence 01000000..36000000, eng_opcode=0 throughout. eng_rcon and eng_data are stable from ISSUE through the eng_valid_out cycle.
- start pulsed at cycle 10 and 20 during a run -> ignored: the same keys and done at cycle 51. A second start after done -> keys_valid drops the next cycle and re-expansion completes.
- Engine stub never asserts eng_valid_out -> error=1 after 16 WAIT cycles, busy=0, keys_valid=0. A later start clears error and completes normally.
- Reset asserted at cycle 23 mid-run, stub keeps emitting eng_valid_out -> all outputs 0, no storage writes, keys_valid stays 0.
- Variable-latency stub (latency 2, 7, 15 randomly per round) -> correct keys, with done exactly one cycle after the tenth eng_valid_out.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-expansion constants, FSM state encoding and the Rcon table.
package aes_pkg;

  localparam int AES_KEY_LEN     = 128;
  localparam int AES_WORD_LEN    = 32;
  localparam int NUM_ROUNDS_128  = 10;
  localparam int AES_ENG_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Round constant for round r (1..10) in the MSB byte of a word; 0 elsewhere.
  function automatic logic [AES_WORD_LEN-1:0] rcon(input logic [3:0] r);
    logic [7:0] b;
    case (r)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1B;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/aes_key_expand_ctrl_if.sv
// Request/response bus between the key-expansion controller and the
// single-round subkey engine.
interface aes_key_expand_ctrl_if
  import aes_pkg::*;
#(
  parameter int KEY_LEN  = AES_KEY_LEN,
  parameter int WORD_LEN = AES_WORD_LEN
);

  logic                eng_valid;
  logic [KEY_LEN-1:0]  eng_data;
  logic                eng_opcode;
  logic [WORD_LEN-1:0] eng_rcon;
  logic                eng_valid_out;
  logic [KEY_LEN-1:0]  eng_data_out;

  // Controller side: issues requests, receives engine results.
  modport master (
    output eng_valid,
    output eng_data,
    output eng_opcode,
    output eng_rcon,
    input  eng_valid_out,
    input  eng_data_out
  );

  // Engine side: receives requests, returns results.
  modport slave (
    input  eng_valid,
    input  eng_data,
    input  eng_opcode,
    input  eng_rcon,
    output eng_valid_out,
    output eng_data_out
  );

endinterface

// File: rtl/aes_round_key_rf.sv
// Round-key storage: one synchronous write port and a registered read port.
// A read of a slot in the same cycle it is written returns the old contents.
module aes_round_key_rf #(
  parameter int KEY_LEN  = 128,
  parameter int NUM_KEYS = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [3:0]         waddr,
  input  logic [KEY_LEN-1:0] wdata,
  input  logic [3:0]         rd_addr,
  output logic [KEY_LEN-1:0] rd_data
);

  localparam logic [3:0] MAX_IDX = 4'(NUM_KEYS - 1);

  logic [KEY_LEN-1:0] mem [0:NUM_KEYS-1];

  // Key slots are deliberately not reset; validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we && (waddr <= MAX_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read, out-of-range indices read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_addr <= MAX_IDX) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key-expansion sequencer: drives the single-round subkey engine ten
// times, stores all eleven round keys and guards against a hung engine.
module aes_key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_LEN     = AES_KEY_LEN,
  parameter int WORD_LEN    = AES_WORD_LEN,
  parameter int NUM_ROUNDS  = NUM_ROUNDS_128,
  parameter int ENG_TIMEOUT = AES_ENG_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_LEN-1:0]    key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  output logic                  error,
  input  logic [3:0]            rd_addr,
  output logic [KEY_LEN-1:0]    rd_data,
  aes_key_expand_ctrl_if.master eng
);

  localparam int              WD_W       = $clog2(ENG_TIMEOUT + 1);
  localparam logic [3:0]      LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(ENG_TIMEOUT - 1);

  state_t              state;
  state_t              state_nx;
  logic [3:0]          round;
  logic [WD_W-1:0]     wdog;
  logic [KEY_LEN-1:0]  eng_data_q;
  logic [WORD_LEN-1:0] eng_rcon_q;

  logic                accept;
  logic                result;
  logic                last_round;
  logic                wd_expire;

  logic                rf_we;
  logic [3:0]          rf_waddr;
  logic [KEY_LEN-1:0]  rf_wdata;

  // A start is only honoured when no run is in flight.
  assign accept     = start && ((state == ST_IDLE) || (state == ST_ERR));
  assign result     = (state == ST_WAIT) && eng.eng_valid_out;
  assign last_round = (round == LAST_ROUND);
  assign wd_expire  = (state == ST_WAIT) && !eng.eng_valid_out && (wdog == WD_LIMIT);

  // Request data and Rcon are held in registers so they stay stable for the
  // whole request, including the engine's output stage.
  assign eng.eng_data = eng_data_q;
  assign eng.eng_rcon = eng_rcon_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; the engine latency is unbounded except by the watchdog.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (start) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng.eng_valid_out) begin
          state_nx = last_round ? ST_IDLE : ST_ISSUE;
        end else if (wd_expire) begin
          state_nx = ST_ERR;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State-decoded outputs and the storage write port selection.
  always_comb begin
    busy           = (state == ST_ISSUE) || (state == ST_WAIT);
    eng.eng_valid  = (state == ST_ISSUE);
    eng.eng_opcode = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = 4'd0;
    rf_wdata       = key_in;
    if (accept) begin
      rf_we    = 1'b1;
      rf_waddr = 4'd0;
      rf_wdata = key_in;
    end else if (result) begin
      rf_we    = 1'b1;
      rf_waddr = round;
      rf_wdata = eng.eng_data_out;
    end
  end

  // Round counter, watchdog, engine request registers and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round      <= 4'd0;
      wdog       <= '0;
      eng_data_q <= '0;
      eng_rcon_q <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        round      <= 4'd1;
        eng_data_q <= key_in;
        eng_rcon_q <= rcon(4'd1);
        keys_valid <= 1'b0;
        error      <= 1'b0;
      end
      if (state == ST_ISSUE) begin
        wdog <= '0;
      end
      if (result) begin
        eng_data_q <= eng.eng_data_out;
        if (last_round) begin
          done       <= 1'b1;
          keys_valid <= 1'b1;
        end else begin
          round      <= round + 4'd1;
          eng_rcon_q <= rcon(round + 4'd1);
        end
      end else if (state == ST_WAIT) begin
        if (wd_expire) begin
          error <= 1'b1;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

  aes_round_key_rf #(
    .KEY_LEN  (KEY_LEN),
    .NUM_KEYS (NUM_ROUNDS + 1)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: a behavioural subkey engine with selectable
// latency, a word-level FIPS-197 key-schedule reference model, and directed
// plus randomised runs.
module tb_aes_key_expand_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         error;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;

  aes_key_expand_ctrl_if eng_if ();

  aes_key_expand_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .error      (error),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .eng        (eng_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]   sbox      [256];
  logic [7:0]   ref_rc    [11];
  logic [127:0] cur_ref   [11];
  logic [127:0] mem_model [11];

  int           run_start = 0;
  int           eng_mode = 0;
  int           eng_cnt = 0;
  int           issue_idx = 0;
  int           seen_run = -1;
  int           last_strobe_cyc = 0;
  logic [127:0] cap_data;
  logic [31:0]  cap_rcon;

  // Cycle counter used for all latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One round of the key schedule as the external engine would compute it.
  function automatic logic [127:0] engineRound(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = subWord({k[23:0], k[31:24]}) ^ rc;
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic buildTables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    ref_rc[0] = 8'h00;
    ref_rc[1] = 8'h01;
    for (int i = 2; i < 11; i++) ref_rc[i] = xtime(ref_rc[i-1]);
  endtask

  // Word-by-word FIPS-197 expansion into the 11 expected round keys.
  task automatic expandRef(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subWord({t[23:0], t[31:24]}) ^ {ref_rc[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) cur_ref[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  // Behavioural engine plus request monitor. Modes: 0 latency 4,
  // 1 latency 2/7/15 per request, 2 never answers, 3 strobes every cycle.
  always @(negedge clk) begin
    if (run_start != seen_run) begin
      seen_run  = run_start;
      issue_idx = 0;
    end
    eng_if.eng_valid_out = 1'b0;
    eng_if.eng_data_out  = rand128();
    if (eng_mode == 3) begin
      eng_cnt = 0;
      eng_if.eng_valid_out = 1'b1;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_if.eng_valid_out = 1'b1;
        eng_if.eng_data_out  = engineRound(cap_data, eng_if.eng_rcon);
        last_strobe_cyc      = cyc;
        checkOutput("hold_data", eng_if.eng_data, cap_data);
        checkOutput("hold_rcon", 128'(eng_if.eng_rcon), 128'(cap_rcon));
      end
    end
    if (eng_if.eng_valid === 1'b1 && eng_mode != 3) begin
      issue_idx++;
      if (issue_idx > 10) begin
        checkOutput("issue_count", 128'(issue_idx), 128'(10));
      end else begin
        checkOutput($sformatf("issue%0d_rcon", issue_idx), 128'(eng_if.eng_rcon),
                    128'({ref_rc[issue_idx], 24'h0}));
        checkOutput($sformatf("issue%0d_data", issue_idx), eng_if.eng_data, cur_ref[issue_idx-1]);
      end
      checkOutput("issue_opcode", 128'(eng_if.eng_opcode), '0);
      cap_data = eng_if.eng_data;
      cap_rcon = eng_if.eng_rcon;
      case (eng_mode)
        0: eng_cnt = 4;
        1: case ($urandom_range(0, 2))
             0:       eng_cnt = 2;
             1:       eng_cnt = 7;
             default: eng_cnt = 15;
           endcase
        default: eng_cnt = 0;
      endcase
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start with a key in the current cycle; returns one cycle later.
  task automatic applyStimulus(input logic [127:0] key);
    start     = 1'b1;
    key_in    = key;
    run_start = cyc;
    @(negedge clk);
    start  = 1'b0;
    key_in = rand128();
  endtask

  // Step until done, optionally pulsing start at relative cycles 10 and 20.
  task automatic runToDone(input int budget, input bit intrude, output int done_rel);
    int rel;
    done_rel = -1;
    for (int i = 0; i < budget && done_rel < 0; i++) begin
      rel = cyc - run_start;
      if (done === 1'b1) begin
        done_rel = rel;
      end else begin
        start = intrude && (rel == 10 || rel == 20);
        if (start) key_in = rand128();
        @(negedge clk);
      end
    end
    start = 1'b0;
    checkOutput("done_seen", 128'(done_rel >= 0), 128'(1));
  endtask

  task automatic readKey(input int addr, output logic [127:0] data);
    rd_addr = 4'(addr);
    @(negedge clk);
    data = rd_data;
  endtask

  task automatic readAll(input string tag);
    logic [127:0] d;
    for (int i = 0; i < 11; i++) begin
      readKey(i, d);
      checkOutput($sformatf("%s_key%0d", tag, i), d, cur_ref[i]);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},       128'(busy),             '0);
    checkOutput({tag, "_done"},       128'(done),             '0);
    checkOutput({tag, "_keys_valid"}, 128'(keys_valid),       '0);
    checkOutput({tag, "_error"},      128'(error),            '0);
    checkOutput({tag, "_eng_valid"},  128'(eng_if.eng_valid), '0);
    checkOutput({tag, "_rd_data"},    rd_data,                '0);
    checkOutput({tag, "_eng_data"},   eng_if.eng_data,        '0);
    checkOutput({tag, "_eng_rcon"},   128'(eng_if.eng_rcon),  '0);
  endtask

  initial begin
    logic [127:0] d;
    int           done_rel;

    buildTables();
    reset = 1'b0; start = 1'b0; key_in = '0; rd_addr = 4'd0; eng_mode = 0;

    // Reset values.
    waitCycles(3);
    checkIdle("reset");
    reset = 1'b1;
    waitCycles(2);
    checkOutput("post_reset_busy", 128'(busy), '0);

    // FIPS-197 key with the nominal latency-4 engine.
    $display("[TB] FIPS-197 expansion");
    expandRef(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    applyStimulus(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    checkOutput("fips_busy", 128'(busy), 128'(1));
    runToDone(80, 1'b0, done_rel);
    checkOutput("fips_done_cycle", 128'(done_rel), 128'(51));
    checkOutput("fips_keys_valid", 128'(keys_valid), 128'(1));
    waitCycles(1);
    checkOutput("fips_done_pulse", 128'(done), '0);
    checkOutput("fips_idle_busy", 128'(busy), '0);
    readAll("fips");
    readKey(1, d);
    checkOutput("fips_rk1", d, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    readKey(10, d);
    checkOutput("fips_rk10", d, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    readKey(11, d);
    checkOutput("rd_addr11", d, '0);
    readKey(15, d);
    checkOutput("rd_addr15", d, '0);
    for (int i = 0; i < 11; i++) mem_model[i] = cur_ref[i];

    // Starts during a run are ignored.
    $display("[TB] start pulses while busy");
    d = rand128();
    expandRef(d);
    applyStimulus(d);
    runToDone(80, 1'b1, done_rel);
    checkOutput("intrude_done_cycle", 128'(done_rel), 128'(51));
    readAll("intrude");
    for (int i = 0; i < 11; i++) mem_model[i] = cur_ref[i];

    // Restart after done, plus read-during-write of slot 1.
    $display("[TB] restart after done");
    checkOutput("restart_pre_keys_valid", 128'(keys_valid), 128'(1));
    d = rand128();
    expandRef(d);
    applyStimulus(d);
    checkOutput("restart_keys_valid", 128'(keys_valid), '0);
    checkOutput("restart_busy", 128'(busy), 128'(1));
    waitCycles(4);
    rd_addr = 4'd1;
    waitCycles(1);
    checkOutput("rdw_old", rd_data, mem_model[1]);
    waitCycles(1);
    checkOutput("rdw_new", rd_data, cur_ref[1]);
    runToDone(80, 1'b0, done_rel);
    checkOutput("restart_done_cycle", 128'(done_rel), 128'(51));
    readAll("restart");
    for (int i = 0; i < 11; i++) mem_model[i] = cur_ref[i];

    // Silent engine trips the watchdog after 16 WAIT cycles.
    $display("[TB] watchdog");
    eng_mode = 2;
    d = rand128();
    expandRef(d);
    applyStimulus(d);
    waitCycles(16);
    checkOutput("wd_last_wait_error", 128'(error), '0);
    checkOutput("wd_last_wait_busy", 128'(busy), 128'(1));
    waitCycles(1);
    checkOutput("wd_error", 128'(error), 128'(1));
    checkOutput("wd_busy", 128'(busy), '0);
    checkOutput("wd_keys_valid", 128'(keys_valid), '0);
    waitCycles(3);
    checkOutput("wd_error_sticky", 128'(error), 128'(1));
    eng_mode = 1;
    d = rand128();
    expandRef(d);
    applyStimulus(d);
    checkOutput("wd_clear_error", 128'(error), '0);
    runToDone(250, 1'b0, done_rel);
    checkOutput("wd_recover_done_timing", 128'(done_rel + run_start), 128'(last_strobe_cyc + 1));
    readAll("wd_recover");
    for (int i = 0; i < 11; i++) mem_model[i] = cur_ref[i];

    // Reset at cycle 23 of a run while the engine keeps strobing.
    $display("[TB] reset mid-run");
    eng_mode = 0;
    d = rand128();
    expandRef(d);
    applyStimulus(d);
    waitCycles(22);
    reset    = 1'b0;
    eng_mode = 3;
    #1;
    checkIdle("abort");
    waitCycles(3);
    checkIdle("abort_hold");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      waitCycles(1);
      checkOutput($sformatf("abort_busy%0d", i), 128'(busy), '0);
      checkOutput($sformatf("abort_kv%0d", i), 128'(keys_valid), '0);
      checkOutput($sformatf("abort_done%0d", i), 128'(done), '0);
    end
    eng_mode = 0;
    for (int i = 5; i < 11; i++) cur_ref[i] = mem_model[i];
    readAll("abort_mem");

    // Randomised keys with a variable-latency engine.
    $display("[TB] variable-latency runs");
    eng_mode = 1;
    for (int n = 0; n < 2; n++) begin
      d = rand128();
      expandRef(d);
      applyStimulus(d);
      runToDone(250, 1'b0, done_rel);
      checkOutput($sformatf("var%0d_done_timing", n), 128'(done_rel + run_start),
                  128'(last_strobe_cyc + 1));
      readAll($sformatf("var%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
